ss_seq: RTL and testbench

SS_SEQ -- requirements
Module: ss_seq

---
 rtl/ss_seq_if.sv | 32 +++
 rtl/ss_seq.sv | 142 ++++++++++++++
 tb/tb_ss_seq.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/ss_seq_if.sv
// Save-state bus bundle: sequence control plus mapper and state-buffer ports.
// master is the sequencer side, slave is the mapper/buffer environment.
interface ss_seq_if;
  logic       start;
  logic       mode;
  logic [7:0] reg_cnt;
  logic [7:0] exp_idx;
  logic       ss_act;
  logic       ss_we;
  logic [7:0] ss_addr;
  logic [7:0] ss_wdat;
  logic [7:0] ss_rdat;
  logic [7:0] buf_addr;
  logic       buf_we;
  logic [7:0] buf_wdat;
  logic [7:0] buf_rdat;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    input  start, mode, reg_cnt, exp_idx, ss_rdat, buf_rdat,
    output ss_act, ss_we, ss_addr, ss_wdat, buf_addr, buf_we, buf_wdat,
           busy, done, err
  );

  modport slave (
    output start, mode, reg_cnt, exp_idx, ss_rdat, buf_rdat,
    input  ss_act, ss_we, ss_addr, ss_wdat, buf_addr, buf_we, buf_wdat,
           busy, done, err
  );
endinterface

// File: rtl/ss_seq.sv
// Mapper save-state sequencer: copies N mapper registers plus the mapper index
// (address 127) into a state buffer, or restores them after an index check.
module ss_seq (
  input  logic      clk,
  input  logic      rst,
  ss_seq_if.master  bus
);
  typedef enum logic [2:0] {IDLE, S_ADDR, S_CAPT, R_RD, R_CMP, R_WR, FIN} state_t;

  localparam logic [7:0] IDX_ADDR = 8'd127;

  state_t     state;
  logic       pend, chk, mode_q;
  logic [7:0] cnt, idx, exp_q;
  logic       ss_act_q, ss_we_q, buf_we_q, busy_q, done_q, err_q;
  logic [7:0] ss_addr_q, buf_addr_q, buf_wdat_q;
  logic [7:0] cur_addr, nxt_idx, nxt_addr;

  // idx == cnt means the register loop is finished and the index slot is next
  assign cur_addr = (idx == cnt) ? IDX_ADDR : idx;
  assign nxt_idx  = idx + 8'd1;
  assign nxt_addr = (nxt_idx == cnt) ? IDX_ADDR : nxt_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pend       <= 1'b0;
      chk        <= 1'b0;
      mode_q     <= 1'b0;
      cnt        <= 8'd0;
      idx        <= 8'd0;
      exp_q      <= 8'd0;
      ss_act_q   <= 1'b0;
      ss_we_q    <= 1'b0;
      buf_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ss_addr_q  <= 8'd0;
      buf_addr_q <= 8'd0;
      buf_wdat_q <= 8'd0;
    end else begin
      ss_we_q    <= 1'b0;
      buf_we_q   <= 1'b0;
      done_q     <= 1'b0;
      ss_addr_q  <= 8'd0;
      buf_addr_q <= 8'd0;
      buf_wdat_q <= 8'd0;
      case (state)
        IDLE: begin
          // one launch cycle after acceptance; busy/ss_act already gate the CPU
          if (pend) begin
            pend <= 1'b0;
            idx  <= 8'd0;
            chk  <= 1'b1;
            if (!mode_q) begin
              state     <= S_ADDR;
              ss_addr_q <= (cnt == 8'd0) ? IDX_ADDR : 8'd0;
            end else begin
              state      <= R_RD;
              buf_addr_q <= IDX_ADDR;
            end
          end else if (bus.start) begin
            pend     <= 1'b1;
            mode_q   <= bus.mode;
            cnt      <= (bus.reg_cnt > 8'd127) ? 8'd127 : bus.reg_cnt;
            exp_q    <= bus.exp_idx;
            err_q    <= 1'b0;
            busy_q   <= 1'b1;
            ss_act_q <= 1'b1;
          end
        end
        S_ADDR: begin
          state      <= S_CAPT;
          buf_we_q   <= 1'b1;
          buf_addr_q <= cur_addr;
          buf_wdat_q <= bus.ss_rdat;
        end
        S_CAPT: begin
          if (idx == cnt) begin
            state  <= FIN;
            done_q <= 1'b1;
          end else begin
            state     <= S_ADDR;
            idx       <= nxt_idx;
            ss_addr_q <= nxt_addr;
          end
        end
        R_RD: begin
          if (chk) begin
            state <= R_CMP;
          end else begin
            state     <= R_WR;
            ss_we_q   <= 1'b1;
            ss_addr_q <= idx;
          end
        end
        R_CMP: begin
          if (bus.buf_rdat != exp_q) begin
            err_q  <= 1'b1;
            state  <= FIN;
            done_q <= 1'b1;
          end else if (cnt == 8'd0) begin
            state  <= FIN;
            done_q <= 1'b1;
          end else begin
            chk   <= 1'b0;
            state <= R_RD;
          end
        end
        R_WR: begin
          if (nxt_idx == cnt) begin
            state  <= FIN;
            done_q <= 1'b1;
          end else begin
            state      <= R_RD;
            idx        <= nxt_idx;
            buf_addr_q <= nxt_idx;
          end
        end
        FIN: begin
          state    <= IDLE;
          busy_q   <= 1'b0;
          ss_act_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ss_act   = ss_act_q;
  assign bus.ss_we    = ss_we_q;
  assign bus.ss_addr  = ss_addr_q;
  // buffer data only arrives in the write cycle, so it is forwarded unregistered
  assign bus.ss_wdat  = ss_we_q ? bus.buf_rdat : 8'd0;
  assign bus.buf_addr = buf_addr_q;
  assign bus.buf_we   = buf_we_q;
  assign bus.buf_wdat = buf_wdat_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_ss_seq.sv
// Scoreboard bench for ss_seq: stimulus predicts every strobe and the done pulse
// from the transfer rules; a negedge monitor pops and compares.
module tb_ss_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ss_seq_if bus();
  ss_seq dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] map [256];
  logic [7:0] mem [256];
  logic [7:0] ld_map [256];
  logic [7:0] ld_mem [256];
  logic       ld = 1'b0;

  // mapper: combinational read; buffer: one-cycle registered read
  assign bus.ss_rdat = map[bus.ss_addr];
  always @(posedge clk) begin
    if (ld) begin
      for (int i = 0; i < 256; i++) begin
        map[i] <= ld_map[i];
        mem[i] <= ld_mem[i];
      end
    end else begin
      if (bus.buf_we) mem[bus.buf_addr] <= bus.buf_wdat;
      if (bus.ss_we)  map[bus.ss_addr]  <= bus.ss_wdat;
    end
    bus.buf_rdat <= mem[bus.buf_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;   // 0 buffer write, 1 mapper write, 2 done
    int addr;
    int data;   // err value for done
    int cyc;
  } ev_t;
  ev_t q[$];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.ss_we && bus.buf_we) chk("strobe exclusive", 1, 0);
      if (bus.ss_we || bus.buf_we || bus.done) begin
        int k, a, d;
        ev_t e;
        if (bus.done)       begin k = 2; a = 0; d = int'(bus.err); end
        else if (bus.ss_we) begin k = 1; a = int'(bus.ss_addr);  d = int'(bus.ss_wdat); end
        else                begin k = 0; a = int'(bus.buf_addr); d = int'(bus.buf_wdat); end
        if (q.size() == 0) begin
          chk("unexpected event kind", k, -1);
        end else begin
          e = q.pop_front();
          chk("event kind", k, e.kind);
          if (k != 2) chk("event addr", a, e.addr);
          chk(k == 2 ? "done err" : "event data", d, e.data);
          chk("event cycle", cyc, e.cyc);
        end
      end
    end
  end

  function automatic int outs_or();
    return int'(bus.ss_act) | int'(bus.ss_we) | int'(bus.ss_addr) | int'(bus.ss_wdat)
         | int'(bus.buf_addr) | int'(bus.buf_we) | int'(bus.buf_wdat) | int'(bus.busy)
         | int'(bus.done) | int'(bus.err);
  endfunction

  task automatic load();
    @(negedge clk);
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic push(input int k, input int a, input int d, input int c);
    ev_t e;
    e.kind = k; e.addr = a; e.data = d; e.cyc = c;
    q.push_back(e);
  endtask

  // intr: wait-loop iteration at which a stray start is pulsed (0 = none)
  // rst_at: cycle offset after acceptance at which reset is raised (0 = none)
  task automatic run_seq(input bit md, input int rc, input int ex, input int intr, input int rst_at);
    logic [7:0] snap_map [256];
    logic [7:0] snap_mem [256];
    logic [7:0] exp_map  [256];
    logic [7:0] exp_mem  [256];
    int n, kk, nn, lim, dm, db;
    bit match, aborted;
    @(negedge clk);
    snap_map = map;
    snap_mem = mem;
    bus.start   = 1'b1;
    bus.mode    = md;
    bus.reg_cnt = 8'(rc);
    bus.exp_idx = 8'(ex);
    @(negedge clk);
    bus.start = 1'b0;
    kk = cyc;
    chk("busy after start", int'(bus.busy), 1);
    chk("err cleared on start", int'(bus.err), 0);
    nn = (rc > 127) ? 127 : rc;
    match = (snap_mem[127] == 8'(ex));
    if (!md) begin
      for (int i = 0; i < nn; i++) push(0, i, int'(snap_map[i]), kk + 2*i + 2);
      push(0, 127, int'(snap_map[127]), kk + 2*nn + 2);
      push(2, 0, 0, kk + 2*nn + 3);
    end else if (match) begin
      for (int i = 0; i < nn; i++) push(1, i, int'(snap_mem[i]), kk + 2*i + 4);
      push(2, 0, 0, kk + 2*nn + 3);
    end else begin
      push(2, 0, 1, kk + 3);
    end
    n = 0;
    aborted = 1'b0;
    while (q.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
      if (intr != 0 && n == intr) begin
        bus.start = 1'b1; bus.mode = ~md; bus.reg_cnt = 8'd3; bus.exp_idx = 8'(ex + 1);
      end else begin
        bus.start = 1'b0;
      end
      if (rst_at != 0 && cyc == kk + rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("outputs zero after mid reset", outs_or(), 0);
        rst = 1'b0;
        q.delete();
        aborted = 1'b1;
      end
    end
    bus.start = 1'b0;
    if (q.size() > 0) chk("timeout pending events", q.size(), 0);
    q.delete();
    repeat (aborted ? 20 : 3) @(negedge clk);
    if (!aborted) chk("idle after done", int'(bus.busy), 0);
    exp_map = snap_map;
    exp_mem = snap_mem;
    if (!md) begin
      for (int i = 0; i < nn; i++) exp_mem[i] = snap_map[i];
      exp_mem[127] = snap_map[127];
    end else if (match) begin
      lim = aborted ? 3 : nn;
      for (int i = 0; i < lim; i++) exp_map[i] = snap_mem[i];
    end
    dm = 0; db = 0;
    for (int i = 0; i < 256; i++) begin
      if (map[i] !== exp_map[i]) dm++;
      if (mem[i] !== exp_mem[i]) db++;
    end
    chk("mapper contents diffs", dm, 0);
    chk("buffer contents diffs", db, 0);
  endtask

  initial begin
    int rc, ex;
    bit md;
    bus.start = 1'b0; bus.mode = 1'b0; bus.reg_cnt = 8'd0; bus.exp_idx = 8'd0;
    for (int i = 0; i < 256; i++) begin
      ld_map[i] = 8'($urandom);
      ld_mem[i] = 8'($urandom);
    end
    ld_map[0] = 8'h11; ld_map[1] = 8'h22; ld_map[2] = 8'h33;
    ld_map[3] = 8'h44; ld_map[4] = 8'h0F; ld_map[127] = 8'hBE;
    ld_mem[127] = 8'h00;
    repeat (3) @(negedge clk);
    chk("outputs zero in reset", outs_or(), 0);
    load();
    rst = 1'b0;

    run_seq(1'b0, 5, 0, 0, 0);            // save 5 regs + index
    chk("buffer[4] after save", int'(mem[4]), 8'h0F);
    chk("buffer[127] after save", int'(mem[127]), 8'hBE);
    run_seq(1'b1, 5, 8'hBE, 0, 0);        // matching restore
    run_seq(1'b1, 5, 8'hBF, 0, 0);        // index mismatch
    repeat (2) @(negedge clk);
    chk("err sticky", int'(bus.err), 1);
    run_seq(1'b1, 5, 8'hBE, 0, 0);        // err clears on next start
    run_seq(1'b0, 200, 0, 0, 0);          // clamp to 127
    run_seq(1'b0, 0, 0, 0, 0);            // index only
    run_seq(1'b1, 0, int'(mem[127]), 0, 0);
    run_seq(1'b0, 5, 0, 4, 0);            // start while busy ignored
    run_seq(1'b1, 5, int'(mem[127]), 3, 0);
    run_seq(1'b1, 5, int'(mem[127]), 0, 8); // reset in R_WR of reg 2

    for (int t = 0; t < 10; t++) begin
      if (t % 3 == 0) begin
        for (int i = 0; i < 256; i++) begin
          ld_map[i] = 8'($urandom);
          ld_mem[i] = 8'($urandom);
        end
        load();
      end
      md = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: rc = $urandom_range(0, 12);
        1: rc = 127;
        2: rc = $urandom_range(128, 255);
        default: rc = $urandom_range(1, 40);
      endcase
      ex = $urandom_range(0, 1) ? int'(mem[127]) : int'(mem[127] + 8'd1);
      run_seq(md, rc, ex, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
